nms_stream: RTL and testbench
=============================

# nms_stream

Streaming 3x3 non-maximum suppression for the FAST9 corner pipeline. It sits after the score stage and accepts one raster-order (score, pixel) pair per transfer. It keeps two score rows and one pixel row in line buffers, plus a 3x3 window, and emits one output per pixel, delayed by one row plus one pixel. Corners are replaced by a marker value; all other pixels pass through unchanged.

## Interface
- SCORE_W, 8, score width (unsigned)
- PIX_W, 8, pixel width
- IMG_W, 640, image width in pixels (>=3)
- IMG_H, 480, image height in rows (>=3)
- CORNER_VAL, 8'hA5, pixel value emitted for a corner (PIX_W wide)
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  input pair valid
- in_ready  out  1  block accepts the pair; transfer when in_valid && in_ready
- in_sof  in  1  first pixel of a frame; qualified by the transfer
- in_score  in  SCORE_W  FAST score, 0 = not a candidate
- in_pixel  in  PIX_W  pixel data
- out_valid  out  1  output word valid; no backpressure
- out_sof  out  1  first centre of the frame
- out_eof  out  1  last centre of the frame
- out_corner  out  1  centre is a surviving corner
- out_pixel  out  PIX_W  CORNER_VAL if corner, else the centre pixel

## Operation
- FSM states are IDLE, RUN and FLUSH.
- **IDLE**
  - in_ready=1.
  - Transfers without in_sof are dropped.
  - A transfer with in_sof loads it as position (0,0) and moves to RUN.
- **RUN**
  - Each transfer advances column/row counters, both line buffers and the window.
  - A transfer with in_sof restarts the frame at (0,0). Pending centres of the old frame are discarded, and no out_eof is issued for the old frame.
  - The transfer of position (IMG_H-1, IMG_W-1) moves to FLUSH.
- **FLUSH**
  - in_ready=0.
  - The block generates IMG_W+1 internal advance steps, one per clock, with score 0 and pixel 0, then returns to IDLE.
- **Output indexing**
  - An advance at input index i (i = row*IMG_W + col, or a flush step continuing the count) completes the window for centre index k = i-(IMG_W+1).
  - An output is produced only for k >= 0, which gives exactly IMG_W*IMG_H outputs per frame.
- **Border**
  - Centres with row 0, row IMG_H-1, col 0 or col IMG_W-1 are never corners. This also masks windows that wrap across a row boundary.
- **Corner rule**
  - The centre is a corner when its score is nonzero, it is not on the border, and it is >= all 8 neighbours.
  - Comparisons are unsigned and SCORE_W wide.
  - Ties therefore pass by default.
- **Markers**
  - out_sof is asserted for k=0.
  - out_eof is asserted for k=IMG_W*IMG_H-1.

## Timing
- Stage 1: the accept/advance edge updates the line buffers and the window registers.
- Stage 2: the next edge registers the compare result into the out_* registers.
- Latency: out_valid is high for exactly one cycle, in the cycle after the stage-2 edge. Total lag is 2 clocks from the completing transfer.
- Throughput is one pair per clock. Gaps in in_valid only delay outputs and never change their values.
- in_ready is registered. It falls on the edge of the final RUN transfer and rises on the edge that ends FLUSH.
- Reset values:
  - All out_* = 0.
  - in_ready = 0; it is 1 from the first edge after rst_n deasserts.
  - State = IDLE; counters = 0.
  - Line-buffer contents need no reset, because the border masking hides them.
- Reset mid-frame aborts immediately. No further out_valid is issued for that frame.

## Configuration
- Macro: NMS_STRICT_TIE_EN.
- Defined: raster-ordered tie-break. The centre must be strictly > its NW, N, NE and W neighbours, and >= its E, SW, S and SE neighbours. In an equal-score plateau, only the first pixel in raster order survives.
- Undefined: >= against all 8 neighbours. Every plateau member is a corner.

## Structure
- Package nms_pkg holds:
  - the FSM state enum (IDLE/RUN/FLUSH);
  - the neighbour index constants (NW..SE);
  - a function for counter width, clog2 of IMG_W/IMG_H.
- Sub-module nms_line_buf: a parametrised WIDTH x DEPTH delay line with a shift enable.
  - 2 instances for scores (WIDTH=SCORE_W, DEPTH=IMG_W).
  - 1 instance for pixels (WIDTH=PIX_W, DEPTH=IMG_W).
- The top level holds the FSM, counters, window registers, compare logic and output registers.

## Test plan
All scenarios use IMG_W=8 and IMG_H=6.
- **Single peak:** score 50 at (2,3), all other scores 10 → 48 outputs; out_corner only at k=19 with out_pixel=8'hA5; every other out_pixel equals the input pixel.
- **Border masking:** peaks of 200 at (0,4), (3,0), (3,7) and (5,2), rest 1 → zero corners.
- **Plateau:** scores 40 at (2,2) and (2,3), rest 5 → default build gives corners at k=18 and k=19; with NMS_STRICT_TIE_EN, only k=18.
- **Frame framing:** all-zero scores, continuous in_valid → no corners; out_sof at the first output, out_eof at the 48th; in_ready low for exactly 9 cycles; a non-sof transfer in IDLE is ignored.
- **Gapped input:** the single-peak frame fed with random in_valid gaps → the output sequence is bit-identical to the gap-free run.
- **Abort:**
  - in_sof at (3,4) mid-frame → the new frame yields 48 clean outputs, with no out_eof from the old frame.
  - rst_n low mid-frame → all outputs read 0 and in_ready reads 0 during reset.

Source files
------------

// File: rtl/nms_pkg.sv
// Shared definitions for the 3x3 non-maximum suppression stream.
//   state_e      : FSM states (IDLE / RUN / FLUSH)
//   NB_*         : neighbour slot indices into the 8-entry neighbour vector,
//                  ordered so slots below NB_E precede the centre in raster order
//   cnt_w()      : counter width for a 0..n-1 counter
package nms_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int NB_NW  = 0;
  localparam int NB_N   = 1;
  localparam int NB_NE  = 2;
  localparam int NB_W   = 3;
  localparam int NB_E   = 4;
  localparam int NB_SW  = 5;
  localparam int NB_S   = 6;
  localparam int NB_SE  = 7;
  localparam int NUM_NB = 8;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nms_line_buf.sv
// WIDTH x DEPTH delay line with shift enable. dout_o is the word that was
// shifted in DEPTH enabled shifts ago. Contents are not reset.
//   clk    : clock
//   en_i   : shift enable
//   din_i  : word shifted in when en_i
//   dout_o : oldest word
module nms_line_buf
  import nms_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 640
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (en_i) mem_q <= {mem_q[DEPTH-2:0], din_i};
  end

  assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/nms_stream.sv
// Streaming 3x3 non-maximum suppression for FAST9 scores. Accepts raster
// (score, pixel) pairs and emits one word per pixel, lagging one row plus
// one pixel; surviving corners have their pixel replaced by CORNER_VAL.
// Optional macro NMS_STRICT_TIE_EN: raster-ordered tie-break (strict > against
// NW, N, NE, W; >= against the rest) so only the first plateau pixel survives.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   in_valid/in_ready/in_sof       : input handshake and frame start
//   in_score, in_pixel             : input pair
//   out_valid, out_sof, out_eof    : output strobe and frame markers
//   out_corner, out_pixel          : corner flag and output pixel
module nms_stream
  import nms_pkg::*;
#(
  parameter int               SCORE_W    = 8,
  parameter int               PIX_W      = 8,
  parameter int               IMG_W      = 640,
  parameter int               IMG_H      = 480,
  parameter logic [PIX_W-1:0] CORNER_VAL = PIX_W'(8'hA5)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sof,
  input  logic [SCORE_W-1:0] in_score,
  input  logic [PIX_W-1:0]   in_pixel,
  output logic               out_valid,
  output logic               out_sof,
  output logic               out_eof,
  output logic               out_corner,
  output logic [PIX_W-1:0]   out_pixel
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam int PW = cnt_w(IMG_W + 2);
  localparam int FW = cnt_w(IMG_W + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [PW-1:0] PRE_FULL = PW'(IMG_W + 1);
  localparam logic [FW-1:0] FL_LAST  = FW'(IMG_W);

  state_e          state_q;
  logic            in_ready_q;
  logic [CW-1:0]   col_q, cc_q;
  logic [RW-1:0]   row_q, cr_q;
  logic [PW-1:0]   pre_q;   // advances seen in this frame, saturates at IMG_W+1
  logic [FW-1:0]   fl_q;

  logic xfer, restart, adv, pre_full, emit;
  logic [SCORE_W-1:0] adv_score;
  logic [PIX_W-1:0]   adv_pix;

  assign xfer     = in_valid && in_ready_q;
  assign restart  = xfer && in_sof;
  assign adv      = (state_q == FLUSH) || (xfer && (in_sof || state_q == RUN));
  assign pre_full = (pre_q == PRE_FULL);
  // The advance at index i completes centre i-(IMG_W+1)
  assign emit     = adv && !restart && pre_full;
  assign adv_score = (state_q == FLUSH) ? '0 : in_score;
  assign adv_pix   = (state_q == FLUSH) ? '0 : in_pixel;
  assign in_ready  = in_ready_q;

  // FSM, input position and centre position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      cc_q       <= '0;
      cr_q       <= '0;
      pre_q      <= '0;
      fl_q       <= '0;
    end else if (restart) begin
      state_q    <= RUN;
      in_ready_q <= 1'b1;
      col_q      <= CW'(1);
      row_q      <= '0;
      cc_q       <= '0;
      cr_q       <= '0;
      pre_q      <= PW'(1);
      fl_q       <= '0;
    end else begin
      case (state_q)
        IDLE: in_ready_q <= 1'b1;
        RUN: begin
          if (xfer) begin
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
            if (col_q == COL_LAST && row_q == ROW_LAST) begin
              state_q    <= FLUSH;
              in_ready_q <= 1'b0;
              fl_q       <= '0;
            end
          end
        end
        FLUSH: begin
          fl_q <= fl_q + FW'(1);
          if (fl_q == FL_LAST) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (adv) begin
        if (!pre_full) begin
          pre_q <= pre_q + PW'(1);
        end else if (cc_q == COL_LAST) begin
          cc_q <= '0;
          cr_q <= (cr_q == ROW_LAST) ? '0 : cr_q + RW'(1);
        end else begin
          cc_q <= cc_q + CW'(1);
        end
      end
    end
  end

  // Line buffers: lb1 yields score(i-W), lb2 score(i-2W), plb pixel(i-W)
  logic [SCORE_W-1:0] lb1_out, lb2_out;
  logic [PIX_W-1:0]   plb_out;

  nms_line_buf #(.WIDTH(SCORE_W), .DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .en_i(adv), .din_i(adv_score), .dout_o(lb1_out));
  nms_line_buf #(.WIDTH(SCORE_W), .DEPTH(IMG_W)) u_lb2 (
    .clk(clk), .en_i(adv), .din_i(lb1_out), .dout_o(lb2_out));
  nms_line_buf #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_plb (
    .clk(clk), .en_i(adv), .din_i(adv_pix), .dout_o(plb_out));

  // Window: win_q[row][col], row 0 = oldest line, col 2 = newest column
  logic [2:0][2:0][SCORE_W-1:0] win_q;
  logic [PIX_W-1:0]             pix_e_q, pix_c_q;
  logic [1:0]                   vld_pipe_q;  // [0] window holds a centre, [1] out regs valid
  logic                         s1_sof_q, s1_eof_q, s1_bord_q;

  logic [NUM_NB-1:0][SCORE_W-1:0] nb;
  logic [SCORE_W-1:0]             ctr;
  logic                           corner_d;

  always_comb begin
    nb        = '0;
    nb[NB_NW] = win_q[0][0];
    nb[NB_N]  = win_q[0][1];
    nb[NB_NE] = win_q[0][2];
    nb[NB_W]  = win_q[1][0];
    nb[NB_E]  = win_q[1][2];
    nb[NB_SW] = win_q[2][0];
    nb[NB_S]  = win_q[2][1];
    nb[NB_SE] = win_q[2][2];
    ctr       = win_q[1][1];
    corner_d  = (ctr != '0) && !s1_bord_q;
    for (int j = 0; j < NUM_NB; j++) begin
`ifdef NMS_STRICT_TIE_EN
      // Raster-earlier neighbours must be beaten strictly
      if (j < NB_E) corner_d = corner_d && (ctr > nb[j]);
      else          corner_d = corner_d && (ctr >= nb[j]);
`else
      corner_d = corner_d && (ctr >= nb[j]);
`endif
    end
  end

  logic out_valid_q, out_sof_q, out_eof_q, out_corner_q;
  logic [PIX_W-1:0] out_pixel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q        <= '0;
      pix_e_q      <= '0;
      pix_c_q      <= '0;
      vld_pipe_q   <= '0;
      s1_sof_q     <= 1'b0;
      s1_eof_q     <= 1'b0;
      s1_bord_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      out_corner_q <= 1'b0;
      out_pixel_q  <= '0;
    end else begin
      // Stage 1: advance window and tag the completed centre
      vld_pipe_q[0] <= emit;
      if (adv) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb2_out;
        win_q[1][2] <= lb1_out;
        win_q[2][2] <= adv_score;
        pix_e_q     <= plb_out;
        pix_c_q     <= pix_e_q;
      end
      if (emit) begin
        s1_sof_q  <= (cc_q == '0) && (cr_q == '0);
        s1_eof_q  <= (cc_q == COL_LAST) && (cr_q == ROW_LAST);
        s1_bord_q <= (cc_q == '0) || (cc_q == COL_LAST) ||
                     (cr_q == '0) || (cr_q == ROW_LAST);
      end
      // Stage 2: register the decision
      vld_pipe_q[1] <= vld_pipe_q[0];
      out_valid_q   <= vld_pipe_q[0];
      out_sof_q     <= vld_pipe_q[0] && s1_sof_q;
      out_eof_q     <= vld_pipe_q[0] && s1_eof_q;
      out_corner_q  <= vld_pipe_q[0] && corner_d;
      out_pixel_q   <= !vld_pipe_q[0] ? '0 : (corner_d ? CORNER_VAL : pix_c_q);
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sof    = out_sof_q;
  assign out_eof    = out_eof_q;
  assign out_corner = out_corner_q;
  assign out_pixel  = out_pixel_q;

endmodule

// File: tb/tb_nms_stream.sv
module tb_nms_stream;
  localparam int W = 8, H = 6, N = W * H, MAXO = 1024;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_sof = 1'b0, in_ready;
  logic [7:0] in_score = '0, in_pixel = '0;
  logic out_valid, out_sof, out_eof, out_corner;
  logic [7:0] out_pixel;

  nms_stream #(.SCORE_W(8), .PIX_W(8), .IMG_W(W), .IMG_H(H), .CORNER_VAL(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_score(in_score), .in_pixel(in_pixel), .out_valid(out_valid), .out_sof(out_sof),
    .out_eof(out_eof), .out_corner(out_corner), .out_pixel(out_pixel));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [7:0]  sc [0:N-1];
  logic [10:0] gold [0:N-1];
  logic [10:0] mo [0:MAXO-1];   // {corner, pixel, sof, eof}
  int mon_n = 0, rdy_low = 0;

  always @(negedge clk) begin
    if (out_valid && mon_n < MAXO) begin
      mo[mon_n] <= {out_corner, out_pixel, out_sof, out_eof};
      mon_n <= mon_n + 1;
    end
    if (rst_n && !in_ready) rdy_low <= rdy_low + 1;
  end

  function automatic logic [7:0] pix_of(input int k);
    return 8'(((k / W) << 4) + (k % W) + 1);
  endfunction

  // Reference NMS over the 2-D score map
  function automatic logic ref_corner(input int k);
    int r, c, j;
    logic ok;
    r = k / W; c = k % W;
    if (r == 0 || r == H-1 || c == 0 || c == W-1 || sc[k] == 0) return 1'b0;
    ok = 1'b1;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        j = (r + dr) * W + (c + dc);
        if (j != k) begin
`ifdef NMS_STRICT_TIE_EN
          if (j < k) ok = ok && (sc[k] > sc[j]);
          else       ok = ok && (sc[k] >= sc[j]);
`else
          ok = ok && (sc[k] >= sc[j]);
`endif
        end
      end
    return ok;
  endfunction

  function automatic logic [10:0] exp_word(input int k);
    logic c;
    c = ref_corner(k);
    return {c, c ? 8'hA5 : pix_of(k), k == 0, k == N-1};
  endfunction

  task automatic xfer(input logic [7:0] s, input logic [7:0] p, input logic sof);
    int n = 0;
    in_valid = 1'b1; in_score = s; in_pixel = p; in_sof = sof;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL xfer_timeout: in_ready=%0b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      xfer(sc[i], pix_of(i), i == 0);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL flush_timeout: in_ready=%0b, required 1", in_ready);
    end
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic check_frame(input int base, input string name);
    tests++;
    if (mon_n - base !== N) begin
      fails++;
      $display("FAIL %s_count: got %0d outputs, required %0d", name, mon_n - base, N);
    end
    for (int k = 0; k < N; k++) begin
      tests++;
      if (mo[base+k] !== exp_word(k)) begin
        fails++;
        $display("FAIL %s_k%0d: got %h, required %h", name, k, mo[base+k], exp_word(k));
      end
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < N; i++) sc[i] = v;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({out_valid, out_sof, out_eof, out_corner, out_pixel, in_ready} !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b/%h rdy=%b, required all 0", {out_valid, out_sof, out_eof, out_corner}, out_pixel, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_rise: got %b, required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single_peak();
    int base, nbk [8];
    nbk = '{10, 11, 12, 18, 20, 26, 27, 28};
    fill(8'd10); sc[19] = 8'd50;
    base = mon_n;
    send_frame(0);
    wait_done();
    check_frame(base, "peak");
    tests++;
    if (mo[base+19][10:2] !== {1'b1, 8'hA5}) begin
      fails++;
      $display("FAIL peak_k19: got %h, required corner with A5", mo[base+19][10:2]);
    end
    foreach (nbk[i]) begin
      tests++;
      if (mo[base+nbk[i]][10:2] !== {1'b0, pix_of(nbk[i])}) begin
        fails++;
        $display("FAIL peak_nb%0d: got %h, required %h", nbk[i], mo[base+nbk[i]][10:2], {1'b0, pix_of(nbk[i])});
      end
    end
    for (int k = 0; k < N; k++) gold[k] = mo[base+k];
  endtask

  task automatic test_border();
    int base, pk [4];
    pk = '{4, 24, 31, 42};
    fill(8'd1);
    foreach (pk[i]) sc[pk[i]] = 8'd200;
    base = mon_n;
    send_frame(0);
    wait_done();
    check_frame(base, "border");
    foreach (pk[i]) begin
      tests++;
      if (mo[base+pk[i]][10:2] !== {1'b0, pix_of(pk[i])}) begin
        fails++;
        $display("FAIL border_k%0d: got %h, required %h", pk[i], mo[base+pk[i]][10:2], {1'b0, pix_of(pk[i])});
      end
    end
  endtask

  task automatic test_plateau();
    int base;
    fill(8'd5); sc[18] = 8'd40; sc[19] = 8'd40;
    base = mon_n;
    send_frame(0);
    wait_done();
    check_frame(base, "plateau");
    tests++;
`ifdef NMS_STRICT_TIE_EN
    if ({mo[base+18][10], mo[base+19][10]} !== 2'b10) begin
`else
    if ({mo[base+18][10], mo[base+19][10]} !== 2'b11) begin
`endif
      fails++;
      $display("FAIL plateau_k18_k19: got %b%b", mo[base+18][10], mo[base+19][10]);
    end
  endtask

  task automatic test_framing();
    int base, r0, ncor, nsof, neof;
    // stray transfer without sof while idle
    base = mon_n;
    xfer(8'd200, 8'h77, 1'b0);
    repeat (6) @(negedge clk);
    #1;
    tests++;
    if (mon_n !== base) begin
      fails++;
      $display("FAIL idle_drop: got %0d outputs, required 0", mon_n - base);
    end
    fill(8'd0);
    base = mon_n; r0 = rdy_low;
    send_frame(0);
    wait_done();
    check_frame(base, "framing");
    tests++;
    if (rdy_low - r0 !== W + 1) begin
      fails++;
      $display("FAIL ready_low_cycles: got %0d, required %0d", rdy_low - r0, W + 1);
    end
    ncor = 0; nsof = 0; neof = 0;
    for (int k = 0; k < N; k++) begin
      ncor += int'(mo[base+k][10]); nsof += int'(mo[base+k][1]); neof += int'(mo[base+k][0]);
    end
    tests++;
    if (ncor !== 0 || nsof !== 1 || neof !== 1 || mo[base][1] !== 1'b1 || mo[base+N-1][0] !== 1'b1) begin
      fails++;
      $display("FAIL framing_markers: corners=%0d sof=%0d eof=%0d, required 0/1/1 at k0/k47", ncor, nsof, neof);
    end
  endtask

  task automatic test_gapped();
    int base;
    fill(8'd10); sc[19] = 8'd50;
    base = mon_n;
    send_frame(3);
    wait_done();
    tests++;
    if (mon_n - base !== N) begin
      fails++;
      $display("FAIL gap_count: got %0d, required %0d", mon_n - base, N);
    end
    for (int k = 0; k < N; k++) begin
      tests++;
      if (mo[base+k] !== gold[k]) begin
        fails++;
        $display("FAIL gap_k%0d: got %h, required %h", k, mo[base+k], gold[k]);
      end
    end
  endtask

  task automatic test_abort_sof();
    int base, s2, nsof, neof;
    fill(8'd10); sc[19] = 8'd50;
    base = mon_n;
    for (int i = 0; i < 3*W + 4; i++) xfer(sc[i], pix_of(i), i == 0);
    fill(8'd5); sc[18] = 8'd40; sc[19] = 8'd40;
    send_frame(0);
    wait_done();
    s2 = -1; nsof = 0; neof = 0;
    for (int k = base; k < mon_n; k++) begin
      if (mo[k][1]) begin nsof++; s2 = k; end
      neof += int'(mo[k][0]);
    end
    tests++;
    if (nsof !== 2 || neof !== 1 || mo[mon_n-1][0] !== 1'b1) begin
      fails++;
      $display("FAIL abort_markers: sof=%0d eof=%0d, required 2 and 1 at end", nsof, neof);
    end
    tests++;
    if (s2 - base > 19) begin
      fails++;
      $display("FAIL abort_old_count: got %0d old outputs, required <=19", s2 - base);
    end
    if (s2 >= 0) check_frame(s2, "abort");
  endtask

  task automatic test_abort_rst();
    int base;
    fill(8'd10); sc[19] = 8'd50;
    for (int i = 0; i < 20; i++) xfer(sc[i], pix_of(i), i == 0);
    rst_n = 1'b0;
    #1;
    base = mon_n;
    for (int c = 0; c < 3; c++) begin
      tests++;
      if ({out_valid, out_sof, out_eof, out_corner, out_pixel, in_ready} !== 13'd0) begin
        fails++;
        $display("FAIL rst_mid_outputs: got %b/%h rdy=%b, required all 0", {out_valid, out_sof, out_eof, out_corner}, out_pixel, in_ready);
      end
      @(negedge clk); #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    tests++;
    if (mon_n !== base) begin
      fails++;
      $display("FAIL rst_no_output: got %0d outputs, required 0", mon_n - base);
    end
    // recovery: a clean frame reproduces the reference stream
    base = mon_n;
    send_frame(0);
    wait_done();
    check_frame(base, "recover");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_single_peak();
    test_border();
    test_plateau();
    test_framing();
    test_gapped();
    test_abort_sof();
    test_abort_rst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
